// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one ALU among NUM_REQ requesters, one operation in flight.
// Optional WAIT-state abort after TIMEOUT cycles is enabled by defining ALU_SCHED_TIMEOUT_EN.
module alu_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CTRL_W  = 4,
  parameter int unsigned TIMEOUT = 16,
  localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_a,
  input  logic [NUM_REQ*DATA_W-1:0]  req_b,
  input  logic [NUM_REQ*CTRL_W-1:0]  req_ctrl,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       alu_valid,
  input  logic                       alu_ready,
  output logic [DATA_W-1:0]          alu_a,
  output logic [DATA_W-1:0]          alu_b,
  output logic [CTRL_W-1:0]          alu_ctrl,
  input  logic                       alu_rsp_valid,
  input  logic [DATA_W:0]            alu_rsp_data,
  output logic                       rsp_valid,
  output logic [ID_W-1:0]            rsp_id,
  output logic [DATA_W:0]            rsp_data,
  output logic                       rsp_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic                alu_valid_q, alu_valid_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [CTRL_W-1:0]   alu_ctrl_q, alu_ctrl_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [DATA_W:0]     rsp_data_q, rsp_data_d;

  logic                pick_found;
  logic [ID_W-1:0]     pick_idx;
  logic [ID_W-1:0]     cand;

`ifdef ALU_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0]    tmo_q, tmo_d;
  logic                rsp_err_q, rsp_err_d;
`else
  localparam int unsigned timeout_unused = TIMEOUT;
`endif

  // First requesting index at or above rr_q, wrapping past NUM_REQ-1.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((32'(rr_q) + k) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Acceptance is shown in the same IDLE cycle whose edge latches the operands.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && !reset && pick_found) req_ready[pick_idx] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    alu_valid_d = alu_valid_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_ctrl_d  = alu_ctrl_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
`ifdef ALU_SCHED_TIMEOUT_EN
    tmo_d       = tmo_q;
    rsp_err_d   = rsp_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d     = pick_idx;
          alu_a_d     = req_a[32'(pick_idx)*DATA_W +: DATA_W];
          alu_b_d     = req_b[32'(pick_idx)*DATA_W +: DATA_W];
          alu_ctrl_d  = req_ctrl[32'(pick_idx)*CTRL_W +: CTRL_W];
          alu_valid_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (alu_ready) begin
          alu_valid_d = 1'b0;
          state_d     = WAIT;
`ifdef ALU_SCHED_TIMEOUT_EN
          tmo_d       = '0;
`endif
        end
      end
      WAIT: begin
        if (alu_rsp_valid) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = grant_q;
          rsp_data_d  = alu_rsp_data;
          state_d     = RESP;
`ifdef ALU_SCHED_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (tmo_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = grant_q;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end else begin
          tmo_d       = tmo_q + 1'b1;
`endif
        end
      end
      RESP: begin
        rr_d    = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      grant_q     <= '0;
      alu_valid_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
`ifdef ALU_SCHED_TIMEOUT_EN
      tmo_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      alu_valid_q <= alu_valid_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_ctrl_q  <= alu_ctrl_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
`ifdef ALU_SCHED_TIMEOUT_EN
      tmo_q       <= tmo_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign alu_valid = alu_valid_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
`ifdef ALU_SCHED_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_scheduler.sv
// Scoreboard bench for alu_scheduler: requester driver, ALU model and response monitor run
// as separate processes; the reference is round-robin arbitration over per-requester queues.
module tb_alu_scheduler;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  typedef struct { logic [DW-1:0] a; logic [DW-1:0] b; logic [CW-1:0] ctrl; } op_t;
  typedef struct { int unsigned id; logic [DW:0] data; } rsp_t;

  logic              clock = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_a, req_b;
  logic [N*CW-1:0]   req_ctrl;
  logic [N-1:0]      req_ready;
  logic              alu_valid, alu_ready;
  logic [DW-1:0]     alu_a, alu_b;
  logic [CW-1:0]     alu_ctrl;
  logic              alu_rsp_valid;
  logic [DW:0]       alu_rsp_data;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [DW:0]       rsp_data;
  logic              rsp_err;

  alu_scheduler #(.NUM_REQ(N), .DATA_W(DW), .CTRL_W(CW), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
    .req_ready(req_ready),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_rsp_valid(alu_rsp_valid), .alu_rsp_data(alu_rsp_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clock = ~clock;

  int unsigned total = 0;
  int unsigned bad   = 0;

  op_t         ops[N][$];
  op_t         iss_q[$];
  rsp_t        exp_q[$];
  bit          busy      = 1'b0;
  int unsigned rr_m      = 0;
  bit          alu_rand  = 1'b0;
  bit          alu_hold  = 1'b0;
  bit          stray_en  = 1'b0;
  int unsigned ready_low = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Behaviour of the external ALU as seen by the bench.
  function automatic logic [DW:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [CW-1:0] c);
    case (c[1:0])
      2'd0:    return {1'b0, a} + {1'b0, b};
      2'd1:    return {1'b0, a} - {1'b0, b};
      2'd2:    return {1'b0, a & b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  task automatic push_op(input int unsigned r, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [CW-1:0] c);
    op_t o;
    o.a = a; o.b = b; o.ctrl = c;
    ops[r].push_back(o);
  endtask

  // Requester side: predicts the round-robin grant and feeds the scoreboard on acceptance.
  initial begin : driver
    logic [N-1:0] acc, expr;
    int unsigned  c, g;
    op_t          o;
    forever begin
      @(negedge clock);
      acc  = req_ready;
      expr = '0;
      g    = 0;
      if (reset) begin
        busy = 1'b0;
        rr_m = 0;
      end else if (!busy) begin
        for (int k = 0; k < int'(N); k++) begin
          c = (rr_m + k) % N;
          if (req_valid[c] && expr == '0) begin
            expr[c] = 1'b1;
            g = c;
          end
        end
      end
      chk("req_ready", 32'(acc), 32'(expr));
      if (expr != '0) begin
        o = ops[g][0];
        iss_q.push_back(o);
        exp_q.push_back('{id: g, data: alu_fn(o.a, o.b, o.ctrl)});
        rr_m = (g + 1) % N;
        busy = 1'b1;
      end
      if (rsp_valid && !reset) busy = 1'b0;
      @(posedge clock);
      #1;
      for (int i = 0; i < int'(N); i++) begin
        if (expr[i]) begin
          void'(ops[i].pop_front());
          req_valid[i] = 1'b0;
        end
        if (!req_valid[i] && ops[i].size() > 0) begin
          req_valid[i]          = 1'b1;
          req_a[i*DW +: DW]     = ops[i][0].a;
          req_b[i*DW +: DW]     = ops[i][0].b;
          req_ctrl[i*CW +: CW]  = ops[i][0].ctrl;
        end
      end
    end
  end

  // ALU model: checks presented operands, responds after a delay, injects stray responses.
  initial begin : alu_model
    bit          hs, pend;
    logic [DW:0] res, pend_res;
    int unsigned dly;
    pend = 1'b0; dly = 0; pend_res = '0;
    forever begin
      @(negedge clock);
      hs  = 1'b0;
      res = '0;
      if (!reset && alu_valid) begin
        if (iss_q.size() == 0) begin
          chk("alu_valid_unexpected", 32'(alu_valid), 32'd0);
        end else begin
          chk("alu_a", 32'(alu_a), 32'(iss_q[0].a));
          chk("alu_b", 32'(alu_b), 32'(iss_q[0].b));
          chk("alu_ctrl", 32'(alu_ctrl), 32'(iss_q[0].ctrl));
          if (alu_ready) begin
            hs  = 1'b1;
            res = alu_fn(iss_q[0].a, iss_q[0].b, iss_q[0].ctrl);
            void'(iss_q.pop_front());
          end
        end
      end
      @(posedge clock);
      #1;
      alu_rsp_valid = 1'b0;
      if (reset) begin
        pend = 1'b0;
      end else begin
        if (hs) begin
          pend     = 1'b1;
          pend_res = res;
          dly      = alu_rand ? $urandom_range(0, 3) : 0;
        end
        if (pend && !alu_hold) begin
          if (dly == 0) begin
            alu_rsp_valid = 1'b1;
            alu_rsp_data  = pend_res;
            pend          = 1'b0;
          end else begin
            dly--;
          end
        end else if (!pend && stray_en && $urandom_range(0, 1) == 0) begin
          alu_rsp_valid = 1'b1;
          alu_rsp_data  = (DW+1)'($urandom);
        end
      end
      if (ready_low > 0) begin
        alu_ready = 1'b0;
        ready_low--;
      end else begin
        alu_ready = alu_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  end

  // Response monitor: pops the scoreboard on every rsp_valid, checks hold otherwise.
  initial begin : monitor
    rsp_t        e;
    int unsigned last_id   = 0;
    logic [DW:0] last_data = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        chk("rsp_valid_in_reset", 32'(rsp_valid), 32'd0);
        last_id   = 0;
        last_data = '0;
      end else if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id", 32'(rsp_id), e.id);
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
          chk("rsp_err", 32'(rsp_err), 32'd0);
          last_id   = e.id;
          last_data = e.data;
        end
      end else begin
        chk("rsp_id_hold", 32'(rsp_id), last_id);
        chk("rsp_data_hold", 32'(rsp_data), 32'(last_data));
      end
    end
  end

  task automatic wait_grant(input int unsigned r);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (req_ready[r]) return;
    end
    chk("grant_timeout", 32'(req_ready[r]), 32'd1);
  endtask

  task automatic drain(input int unsigned limit);
    bit idle;
    for (int unsigned i = 0; i < limit; i++) begin
      @(negedge clock);
      idle = !busy && exp_q.size() == 0 && iss_q.size() == 0;
      for (int r = 0; r < int'(N); r++) if (ops[r].size() != 0) idle = 1'b0;
      if (idle) return;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks", total);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int unsigned lat;
    int          order[5];
    int          exp_order[5];
    int          n;
    reset = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; req_ctrl = '0;
    alu_ready = 1'b1; alu_rsp_valid = 1'b0; alu_rsp_data = '0;
    exp_order = '{0, 1, 2, 3, 0};

    repeat (3) @(negedge clock);
    chk("rst_alu_valid", 32'(alu_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    #2 reset = 1'b0;

    // Lone requester 2, immediate ALU: result three edges after acceptance.
    @(negedge clock); #2;
    push_op(2, 8'h7F, 8'h01, 4'h0);
    wait_grant(2);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      lat++;
      if (rsp_valid) break;
    end
    chk("latency", lat, 32'd3);
    chk("lat_rsp_id", 32'(rsp_id), 32'd2);
    chk("lat_rsp_data", 32'(rsp_data), 32'h080);
    drain(100);

    // ALU stalls in ISSUE: operands stable, no further acceptance.
    @(negedge clock); #2;
    ready_low = 8;
    push_op(3, 8'hA5, 8'h3C, 4'h2);
    push_op(0, 8'h11, 8'h22, 4'h1);
    wait_grant(3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("stall_alu_valid", 32'(alu_valid), 32'd1);
      chk("stall_alu_a", 32'(alu_a), 32'hA5);
      chk("stall_alu_b", 32'(alu_b), 32'h3C);
      chk("stall_alu_ctrl", 32'(alu_ctrl), 32'h2);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    drain(100);

    // Reset while waiting on the ALU, then stray responses must be ignored.
    @(negedge clock); #2;
    alu_hold = 1'b1;
    push_op(1, 8'h33, 8'h44, 4'h3);
    wait_grant(1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (!alu_valid) break;
    end
    #2;
    reset = 1'b1;
    foreach (ops[i]) ops[i].delete();
    iss_q.delete();
    exp_q.delete();
    req_valid = '0;
    alu_hold  = 1'b0;
    stray_en  = 1'b1;
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("post_rst_alu_valid", 32'(alu_valid), 32'd0);
      chk("post_rst_alu_a", 32'(alu_a), 32'd0);
      chk("post_rst_rsp_data", 32'(rsp_data), 32'd0);
      chk("post_rst_rsp_id", 32'(rsp_id), 32'd0);
    end

    // All four requesting, requester 0 twice: grant order after reset.
    #2;
    push_op(0, 8'h01, 8'h02, 4'h0);
    push_op(1, 8'h10, 8'h20, 4'h1);
    push_op(2, 8'hF0, 8'h0F, 4'h2);
    push_op(3, 8'hAA, 8'h55, 4'h3);
    push_op(0, 8'hFF, 8'hFF, 4'h0);
    order = '{-1, -1, -1, -1, -1};
    n = 0;
    for (int i = 0; i < 100 && n < 5; i++) begin
      @(negedge clock);
      for (int r = 0; r < int'(N); r++) begin
        if (req_ready[r]) begin
          order[n] = r;
          n++;
        end
      end
    end
    for (int i = 0; i < 5; i++) chk("rr_order", 32'(order[i]), 32'(exp_order[i]));
    drain(200);

    // Randomized traffic with random ALU stalls, delays and stray responses.
    alu_rand = 1'b1;
    for (int i = 0; i < 800; i++) begin
      @(negedge clock); #2;
      if ($urandom_range(0, 3) == 0)
        push_op($urandom_range(0, N - 1), DW'($urandom), DW'($urandom), CW'($urandom));
    end
    drain(6000);
    repeat (3) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
